// File: rtl/alu_issue_ctrl.sv
// Issue/response controller in front of a combinational 32-bit ALU.
// Holds the architectural flag register and resolves conditional branches against it.
module alu_issue_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic [3:0]    alu_sig,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [2:0]    res_flags,
  output logic          br_taken
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    op_r;
  logic [DW-1:0] cap_data;
  logic [2:0]    cap_flags;
  logic          cap_taken;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  // Branch condition: zero/negative come from the live ALU flags, carry from the stored register.
  function automatic logic branch_cond(input logic [3:0] op, input logic [1:0] zn,
                                       input logic carry);
    logic c;
    case (op)
      4'h9:    c = 1'b1;
      4'hA:    c = zn[0];
      4'hB:    c = ~zn[0];
      4'hC:    c = zn[1];
      4'hD:    c = carry;
      4'hE:    c = ~carry;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);

  // Next-state decode for the issue/response sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = EXEC;
        else          state_nxt = IDLE;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        if (res_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result selection at the end of EXEC.
  always_comb begin
    cap_data  = {DW{1'b0}};
    cap_flags = res_flags;
    cap_taken = 1'b0;
    if (is_alu_op(op_r)) begin
      cap_data  = alu_out;
      cap_flags = alu_flags;
    end else if ((op_r >= 4'h9) && (op_r <= 4'hE)) begin
      cap_taken = branch_cond(op_r, alu_flags[1:0], res_flags[2]);
      cap_data  = cap_taken ? alu_b : {DW{1'b0}};
    end else begin
      cap_data  = {DW{1'b0}};
    end
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= 4'd0;
      alu_sig   <= 4'd0;
      alu_a     <= {DW{1'b0}};
      alu_b     <= {DW{1'b0}};
      res_data  <= {DW{1'b0}};
      res_flags <= 3'd0;
      br_taken  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && in_valid) begin
        op_r    <= in_op;
        alu_a   <= in_a;
        alu_b   <= in_b;
        alu_sig <= is_alu_op(in_op) ? in_op : 4'd0;
      end else if (state == EXEC) begin
        alu_sig   <= 4'd0;
        res_data  <= cap_data;
        res_flags <= cap_flags;
        br_taken  <= cap_taken;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and an op-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  alu_sig;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [2:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic        br_taken;

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] exp_flags;

  alu_issue_ctrl #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_sig(alu_sig), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags, result}; carry only from add, diff = (a-b)>>2.
  function automatic logic [34:0] ref_alu(input logic [3:0] sig, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic        cy;
    sum = {1'b0, a} + {1'b0, b};
    cy  = 1'b0;
    case (sig)
      4'd1: begin r = sum[31:0]; cy = sum[32]; end
      4'd2: r = a & b;
      4'd3: r = ~a;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = (a - b) >> 2;
      default: r = 32'd0;
    endcase
    return {cy, a[31], (a == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_out} = ref_alu(alu_sig, alu_a, alu_b);

  // Issue one op, check latency/drive/hold behaviour, consume it, return the observed response.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got_data,
                        output logic [2:0] got_flags, output logic got_taken);
    logic [31:0] e_data;
    logic        e_taken;
    logic [3:0]  e_sig;
    logic [34:0] alu_res;
    logic        cond;
    e_sig   = (op >= 4'd1 && op <= 4'd8) ? op : 4'd0;
    e_data  = 32'd0;
    e_taken = 1'b0;
    if (e_sig != 4'd0) begin
      alu_res   = ref_alu(op, a, b);
      e_data    = alu_res[31:0];
      exp_flags = alu_res[34:32];
    end else if (op >= 4'h9 && op <= 4'hE) begin
      case (op)
        4'h9: cond = 1'b1;
        4'hA: cond = (a == 32'd0);
        4'hB: cond = (a != 32'd0);
        4'hC: cond = a[31];
        4'hD: cond = exp_flags[2];
        default: cond = ~exp_flags[2];
      endcase
      e_taken = cond;
      e_data  = cond ? b : 32'd0;
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_ready op=%h got=%b want=1", op, in_ready);
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
    compared++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || alu_sig !== e_sig || alu_a !== a || alu_b !== b) begin
      mismatched++;
      $display("FAIL exec_drive op=%h got v=%b r=%b sig=%h a=%h b=%h want v=0 r=0 sig=%h a=%h b=%h",
               op, res_valid, in_ready, alu_sig, alu_a, alu_b, e_sig, a, b);
    end
    @(posedge clk); #1;
    compared++;
    if (res_valid !== 1'b1 || res_data !== e_data || res_flags !== exp_flags || br_taken !== e_taken) begin
      mismatched++;
      $display("FAIL response op=%h got v=%b d=%h f=%b t=%b want v=1 d=%h f=%b t=%b",
               op, res_valid, res_data, res_flags, br_taken, e_data, exp_flags, e_taken);
    end
    got_data = res_data; got_flags = res_flags; got_taken = br_taken;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_op = 4'h1; in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      compared++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || alu_sig !== 4'd0 || res_data !== got_data ||
          res_flags !== got_flags || br_taken !== got_taken) begin
        mismatched++;
        $display("FAIL hold cyc=%0d got v=%b r=%b sig=%h d=%h f=%b t=%b want v=1 r=0 sig=0 d=%h f=%b t=%b",
                 i, res_valid, in_ready, alu_sig, res_data, res_flags, br_taken, got_data, got_flags, got_taken);
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    compared++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL consume got v=%b r=%b want v=0 r=1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0;
    exp_flags = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'd0 || res_flags !== 3'd0 ||
        br_taken !== 1'b0 || alu_sig !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_values got r=%b v=%b d=%h f=%b t=%b sig=%h a=%h b=%h want r=1 rest 0",
               in_ready, res_valid, res_data, res_flags, br_taken, alu_sig, alu_a, alu_b);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'h1, 32'hFFFF_FFFF, 32'h1, 0, d, f, t);
    compared++;
    if (d !== 32'd0 || f !== 3'b110 || t !== 1'b0) begin
      mismatched++;
      $display("FAIL add_carry got d=%h f=%b t=%b want d=0 f=110 t=0", d, f, t);
    end
  endtask

  task automatic test_carry_branches();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'hD, 32'h5, 32'h100, 0, d, f, t);
    compared++;
    if (d !== 32'h100 || t !== 1'b1 || f !== 3'b110) begin
      mismatched++;
      $display("FAIL bcy got d=%h f=%b t=%b want d=100 f=110 t=1", d, f, t);
    end
    run_op(4'h4, 32'h3, 32'h1, 0, d, f, t);
    compared++;
    if (d !== 32'h2 || f !== 3'b000 || t !== 1'b0) begin
      mismatched++;
      $display("FAIL xor got d=%h f=%b t=%b want d=2 f=000 t=0", d, f, t);
    end
    run_op(4'hE, 32'h7, 32'h200, 0, d, f, t);
    compared++;
    if (d !== 32'h200 || t !== 1'b1) begin
      mismatched++;
      $display("FAIL bncy got d=%h t=%b want d=200 t=1", d, t);
    end
  endtask

  task automatic test_zero();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'hA, 32'h0, 32'h40, 0, d, f, t);
    compared++;
    if (d !== 32'h40 || t !== 1'b1) begin
      mismatched++;
      $display("FAIL bz got d=%h t=%b want d=40 t=1", d, t);
    end
    run_op(4'hB, 32'h0, 32'h80, 0, d, f, t);
    compared++;
    if (d !== 32'h0 || t !== 1'b0 || f !== 3'b000) begin
      mismatched++;
      $display("FAIL bnz got d=%h f=%b t=%b want d=0 f=000 t=0", d, f, t);
    end
  endtask

  task automatic test_diff_reserved();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'h1, 32'h8000_0000, 32'h8000_0000, 0, d, f, t);
    run_op(4'h8, 32'h10, 32'h0, 0, d, f, t);
    compared++;
    if (d !== 32'h4 || f !== 3'b000) begin
      mismatched++;
      $display("FAIL diff got d=%h f=%b want d=4 f=000", d, f);
    end
    run_op(4'h1, 32'hF000_0000, 32'h1000_0000, 0, d, f, t);
    run_op(4'hF, 32'h1234, 32'h5678, 0, d, f, t);
    compared++;
    if (d !== 32'h0 || f !== 3'b110 || t !== 1'b0) begin
      mismatched++;
      $display("FAIL reserved got d=%h f=%b t=%b want d=0 f=110 t=0", d, f, t);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5, d, f, t);
    run_op(4'h5, 32'h1, 32'd31, 0, d, f, t);
    compared++;
    if (d !== 32'h8000_0000) begin
      mismatched++;
      $display("FAIL after_backpressure got d=%h want d=80000000", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a; logic [2:0] f; logic t;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom_range(0, 2), d, f, t);
    end
  endtask

  task automatic test_reset_exec();
    logic [31:0] d; logic [2:0] f; logic t;
    run_op(4'h1, 32'hFFFF_FFFF, 32'h3, 0, d, f, t);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'h3; in_a = 32'h55; in_b = 32'h66;
    @(posedge clk); #1;
    in_valid = 1'b0; res_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_flags = 3'd0;
    compared++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'd0 || res_flags !== 3'd0 ||
        br_taken !== 1'b0 || alu_sig !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_exec got r=%b v=%b d=%h f=%b t=%b sig=%h a=%h b=%h want r=1 rest 0",
               in_ready, res_valid, res_data, res_flags, br_taken, alu_sig, alu_a, alu_b);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      compared++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL no_resp_after_reset cyc=%0d got v=%b r=%b want v=0 r=1", i, res_valid, in_ready);
      end
    end
    res_ready = 1'b0;
    run_op(4'hD, 32'h1, 32'h300, 0, d, f, t);
    compared++;
    if (t !== 1'b0 || d !== 32'd0) begin
      mismatched++;
      $display("FAIL bcy_after_reset got d=%h t=%b want d=0 t=0", d, t);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_carry_branches();
    test_zero();
    test_diff_reserved();
    test_backpressure();
    test_random();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
